// File: rtl/spec_pkg.sv
// rtl/spec_pkg.sv - shared types and constants for the sample capture controller
package spec_pkg;

  localparam int FRAME_LEN  = 512;
  localparam int FRAME_AW   = 9;
  localparam int DEF_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] DEC_1 = 2'd0;
  localparam logic [1:0] DEC_2 = 2'd1;
  localparam logic [1:0] DEC_4 = 2'd2;
  localparam logic [1:0] DEC_8 = 2'd3;

  // Prescaler bits that must be zero for a sample to be kept.
  function automatic logic [2:0] dec_mask(input logic [1:0] sel);
    logic [2:0] m;
    case (sel)
      DEC_1:   m = 3'b000;
      DEC_2:   m = 3'b001;
      DEC_4:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decim_prescaler.sv
// rtl/decim_prescaler.sv - 3-bit decimation prescaler with keep decode
module decim_prescaler
  import spec_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [1:0] i_dec_sel,
  output logic       o_keep
);

  logic [2:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 3'd0;
    end else if (i_clr) begin
      r_cnt <= 3'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_keep = ((r_cnt & dec_mask(i_dec_sel)) == 3'd0);

endmodule

// File: rtl/sample_capture_ctrl.sv
// rtl/sample_capture_ctrl.sv - captures one decimated 512-sample frame at bit-reversed RAM addresses
module sample_capture_ctrl
  import spec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        dec_sel,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cnt_load,
  output logic              cnt_inc,
  output logic [8:0]        cnt_din,
  input  logic [8:0]        count,
  input  logic              md512,
  output logic              mem_we,
  output logic [8:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  state_e     r_state;
  state_e     w_next;
  logic [1:0] r_dec_sel;
  logic       r_overrun;
  logic       w_in_capture;
  logic       w_accept;
  logic       w_keep;
  logic       w_write;
  logic       w_start_ok;

  assign w_in_capture = (r_state == ST_CAPTURE);
  assign w_accept     = s_valid & w_in_capture;
  // abort wins over a kept sample so a cancelled frame never writes on its last cycle
  assign w_write      = w_accept & w_keep & ~abort;
  assign w_start_ok   = (r_state == ST_IDLE) & start & ~abort;

  decim_prescaler u_prescaler (
    .i_clk     (Clk),
    .i_rst_n   (Resetn),
    .i_clr     (cnt_load),
    .i_en      (w_accept),
    .i_dec_sel (r_dec_sel),
    .o_keep    (w_keep)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok) w_next = ST_LOAD;
      ST_LOAD:    w_next = abort ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: begin
        if (abort) w_next = ST_IDLE;
        else if (w_write && md512) w_next = ST_DONE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_dec_sel <= DEC_1;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_dec_sel <= dec_sel;
        r_overrun <= 1'b0;
      end else if (s_valid && (r_state == ST_LOAD || r_state == ST_DONE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign s_ready    = w_in_capture;
  assign mem_we     = w_write;
  assign cnt_inc    = w_write & ~md512;
  assign cnt_load   = (r_state == ST_LOAD);
  assign cnt_din    = 9'd0;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign overrun    = r_overrun;
  assign mem_wdata  = s_data;

  // Bit-reversed addressing puts the frame in the order the in-place FFT expects.
  genvar gi;
  generate
    for (gi = 0; gi < FRAME_AW; gi++) begin : g_bitrev
      assign mem_addr[gi] = count[FRAME_AW-1-gi];
    end
  endgenerate

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// tb/tb_sample_capture_ctrl.sv - self-checking bench for sample_capture_ctrl
module tb_sample_capture_ctrl;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        start, abort;
  logic [1:0]  dec_sel;
  logic [11:0] s_data;
  logic        s_valid, s_ready;
  logic        cnt_load, cnt_inc;
  logic [8:0]  cnt_din;
  logic [8:0]  count;
  logic        md512;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic        busy, frame_done, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [11:0] data_arr [0:4095];
  logic [8:0]  wr_addr[$];
  logic [11:0] wr_data[$];
  int          wr_cyc[$];
  int          fd_n, fd_cyc, load_cyc, bad_inc, ovr_drop, start_cyc;
  bit          ovr_watch = 1'b0;

  always #5 Clk = ~Clk;

  sample_capture_ctrl #(.DATA_W(12)) dut (
    .Clk(Clk), .Resetn(Resetn), .start(start), .abort(abort), .dec_sel(dec_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_din(cnt_din),
    .count(count), .md512(md512), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  // Environment: the downstream 9-bit loadable frame counter.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) count <= 9'd0;
    else if (cnt_load) count <= cnt_din;
    else if (cnt_inc) count <= count + 9'd1;
  end
  assign md512 = (count == 9'd511);

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_n++;
      fd_cyc = cyc;
    end
    if (cnt_load) load_cyc = cyc;
    if (cnt_inc && (md512 || !mem_we)) bad_inc++;
    if (ovr_watch && busy && !cnt_load && !overrun) ovr_drop++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    fd_n = 0; fd_cyc = -1; load_cyc = -1; bad_inc = 0; ovr_drop = 0;
  endtask

  function automatic logic [8:0] bitrev(input int k);
    logic [8:0] v, r;
    v = k[8:0];
    for (int i = 0; i < 9; i++) r[i] = v[8-i];
    return r;
  endfunction

  // The k-th kept sample is stream sample k*2^d and lands at bitrev(k).
  function automatic int model_mismatches(input int d, input int n);
    int m = 0;
    for (int k = 0; k < n; k++) begin
      if (k >= wr_addr.size()) m++;
      else if (wr_addr[k] !== bitrev(k) || wr_data[k] !== data_arr[k << d]) m++;
    end
    return m;
  endfunction

  task automatic fill_data(input bit ramp);
    for (int i = 0; i < 4096; i++) data_arr[i] = ramp ? i[11:0] : 12'($urandom);
  endtask

  task automatic drive_frame(input int d, input int gap, input int abort_k,
                             input bit valid_load, input bit start_mid, output bit tmo);
    int idx, last;
    bit acc, ab, done;
    idx = 0; last = 511 << d; done = 0; tmo = 0;
    clear_mon();
    dec_sel = d[1:0]; start = 1'b1; s_valid = valid_load; s_data = data_arr[0];
    start_cyc = cyc;
    tick();
    start = 1'b0; dec_sel = 2'($urandom);
    tick();
    for (int n = 0; n < 40000 && !done; n++) begin
      s_valid = (idx <= last) && ($urandom_range(99) >= gap);
      s_data  = data_arr[idx];
      ab      = s_valid && abort_k >= 0 && idx == (abort_k << d);
      abort   = ab;
      start   = start_mid && idx == 200;
      @(negedge Clk);
      acc = s_valid && s_ready;
      if (frame_done) done = 1;
      tick();
      if (acc && !ab) idx++;
      abort = 1'b0; start = 1'b0;
      if (ab) done = 1;
    end
    s_valid = 1'b0;
    tmo = !done;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; start = 0; abort = 0; dec_sel = 0; s_data = 0; s_valid = 0;
    tick(); tick();
    n_checks++;
    if ({s_ready, cnt_load, cnt_inc, mem_we, busy, frame_done, overrun} !== 7'd0) begin
      n_fail++; $display("FAIL reset_held ctrl=%b required=0", {s_ready, cnt_load, cnt_inc, mem_we, busy, frame_done, overrun});
    end
    @(negedge Clk); Resetn = 1'b1;
    tick();
    n_checks++;
    if ({s_ready, cnt_load, cnt_inc, mem_we, busy, frame_done, overrun, cnt_din, mem_addr} !== 25'd0) begin
      n_fail++; $display("FAIL reset_released ctrl=%b din=%0d addr=%0d required=0", {s_ready, cnt_load, cnt_inc, mem_we, busy, frame_done, overrun}, cnt_din, mem_addr);
    end
  endtask

  task automatic test_full_rate();
    bit tmo;
    fill_data(1'b1);
    drive_frame(0, 0, -1, 1'b0, 1'b0, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL full_timeout got=%0d required=0", tmo); end
    n_checks++; if (wr_addr.size() !== 512) begin n_fail++; $display("FAIL full_writes got=%0d required=512", wr_addr.size()); end
    n_checks++; if (wr_addr[1] !== 9'd256) begin n_fail++; $display("FAIL full_addr1 got=%0d required=256", wr_addr[1]); end
    n_checks++; if (wr_addr[2] !== 9'd128) begin n_fail++; $display("FAIL full_addr2 got=%0d required=128", wr_addr[2]); end
    n_checks++; if (wr_addr[511] !== 9'd511) begin n_fail++; $display("FAIL full_addr511 got=%0d required=511", wr_addr[511]); end
    n_checks++; if (model_mismatches(0, 512) !== 0) begin n_fail++; $display("FAIL full_model mismatches=%0d required=0", model_mismatches(0, 512)); end
    n_checks++; if (load_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL full_load_latency got=%0d required=%0d", load_cyc, start_cyc + 1); end
    n_checks++; if (wr_cyc[0] !== start_cyc + 2) begin n_fail++; $display("FAIL full_write_latency got=%0d required=%0d", wr_cyc[0], start_cyc + 2); end
    n_checks++; if (fd_n !== 1) begin n_fail++; $display("FAIL full_done_count got=%0d required=1", fd_n); end
    n_checks++; if (fd_cyc !== wr_cyc[511] + 1) begin n_fail++; $display("FAIL full_done_cycle got=%0d required=%0d", fd_cyc, wr_cyc[511] + 1); end
    n_checks++; if (bad_inc !== 0) begin n_fail++; $display("FAIL full_inc_at_md512 got=%0d required=0", bad_inc); end
    n_checks++; if ({busy, overrun} !== 2'b00) begin n_fail++; $display("FAIL full_idle_after busy_overrun=%b required=00", {busy, overrun}); end
  endtask

  task automatic test_decim4();
    bit tmo;
    fill_data(1'b1);
    drive_frame(2, 25, -1, 1'b0, 1'b0, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL dec4_timeout got=%0d required=0", tmo); end
    n_checks++; if (wr_addr.size() !== 512) begin n_fail++; $display("FAIL dec4_writes got=%0d required=512", wr_addr.size()); end
    n_checks++; if (wr_data[1] !== 12'd4 || wr_addr[1] !== 9'd256) begin n_fail++; $display("FAIL dec4_second data=%0d addr=%0d required 4/256", wr_data[1], wr_addr[1]); end
    n_checks++; if (model_mismatches(2, 512) !== 0) begin n_fail++; $display("FAIL dec4_model mismatches=%0d required=0", model_mismatches(2, 512)); end
    n_checks++; if (fd_n !== 1 || bad_inc !== 0) begin n_fail++; $display("FAIL dec4_done done=%0d badinc=%0d required 1/0", fd_n, bad_inc); end
  endtask

  task automatic test_abort();
    bit tmo;
    fill_data(1'b0);
    drive_frame(0, 20, 100, 1'b0, 1'b0, tmo);
    n_checks++; if ({busy, s_ready} !== 2'b00) begin n_fail++; $display("FAIL abort_idle busy_ready=%b required=00", {busy, s_ready}); end
    s_valid = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    n_checks++; if (wr_addr.size() !== 100) begin n_fail++; $display("FAIL abort_writes got=%0d required=100", wr_addr.size()); end
    n_checks++; if (model_mismatches(0, 100) !== 0) begin n_fail++; $display("FAIL abort_partial mismatches=%0d required=0", model_mismatches(0, 100)); end
    n_checks++; if (fd_n !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d required=0", fd_n); end
    fill_data(1'b0);
    drive_frame(1, 10, -1, 1'b0, 1'b0, tmo);
    n_checks++; if (wr_addr[0] !== 9'd0 || tmo !== 1'b0) begin n_fail++; $display("FAIL abort_restart addr0=%0d tmo=%0d required 0/0", wr_addr[0], tmo); end
    n_checks++; if (model_mismatches(1, 512) !== 0 || wr_addr.size() !== 512) begin n_fail++; $display("FAIL abort_restart_model mismatches=%0d writes=%0d required 0/512", model_mismatches(1, 512), wr_addr.size()); end
  endtask

  task automatic test_overrun();
    bit tmo;
    fill_data(1'b0);
    ovr_watch = 1'b1;
    drive_frame(3, 0, -1, 1'b1, 1'b0, tmo);
    ovr_watch = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%0d required=1", overrun); end
    n_checks++; if (ovr_drop !== 0) begin n_fail++; $display("FAIL ovr_hold drops=%0d required=0", ovr_drop); end
    n_checks++; if (model_mismatches(3, 512) !== 0 || tmo !== 1'b0) begin n_fail++; $display("FAIL ovr_frame mismatches=%0d tmo=%0d required 0/0", model_mismatches(3, 512), tmo); end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++; if ({overrun, busy} !== 2'b10) begin n_fail++; $display("FAIL ovr_start_abort overrun_busy=%b required=10", {overrun, busy}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({overrun, cnt_load} !== 2'b01) begin n_fail++; $display("FAIL ovr_clear overrun_load=%b required=01", {overrun, cnt_load}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({busy, overrun} !== 2'b00) begin n_fail++; $display("FAIL ovr_abort_load busy_overrun=%b required=00", {busy, overrun}); end
  endtask

  task automatic test_simultaneous();
    bit tmo;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++; if ({busy, cnt_load, s_ready} !== 3'b000) begin n_fail++; $display("FAIL sim_start_abort busy_load_ready=%b required=000", {busy, cnt_load, s_ready}); end
    fill_data(1'b0);
    drive_frame(1, 15, -1, 1'b0, 1'b1, tmo);
    n_checks++; if (tmo !== 1'b0 || fd_n !== 1) begin n_fail++; $display("FAIL sim_start_mid tmo=%0d done=%0d required 0/1", tmo, fd_n); end
    n_checks++; if (model_mismatches(1, 512) !== 0 || wr_addr.size() !== 512) begin n_fail++; $display("FAIL sim_start_mid_model mismatches=%0d writes=%0d required 0/512", model_mismatches(1, 512), wr_addr.size()); end
  endtask

  task automatic test_async_reset();
    bit found;
    clear_mon();
    fill_data(1'b0);
    dec_sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 12'($urandom);
    found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      if (count == 9'd300) found = 1;
      else tick();
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL areset_reach300 got=%0d required=1", found); end
    #2 Resetn = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, cnt_load, cnt_inc, mem_we, busy, frame_done, overrun, mem_addr} !== 16'd0) begin
      n_fail++; $display("FAIL areset_immediate ctrl=%b addr=%0d required=0", {s_ready, cnt_load, cnt_inc, mem_we, busy, frame_done, overrun}, mem_addr);
    end
    s_valid = 1'b0;
    @(negedge Clk); Resetn = 1'b1;
    tick();
    n_checks++; if ({busy, s_ready, frame_done} !== 3'b000) begin n_fail++; $display("FAIL areset_release busy_ready_done=%b required=000", {busy, s_ready, frame_done}); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_decim4();
    test_abort();
    test_overrun();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_capture_ctrl.md
# sample_capture_ctrl

Front-end capture controller for the spectrum analyzer. It accepts ADC samples over a valid/ready stream and optionally decimates them by 1, 2, 4 or 8. It writes one 512-sample frame into the sample RAM at bit-reversed addresses, ready for the in-place FFT. It sits directly upstream of the 9-bit loadable frame address counter (`counter9bit`): it drives that counter's `load`/`inc`/`Din` and consumes its `count` and `md512` terminal-count flag.

## Interface
- `DATA_W`, default 12: sample width.
- `Clk`  in  1: the single clock; all state changes on its rising edge.
- `Resetn`  in  1: reset, asynchronous and active-low.
- `start`  in  1: single-cycle request to begin a frame; honoured only in IDLE.
- `abort`  in  1: cancel the frame in progress.
- `dec_sel`  in  2: decimation select (0 keeps every sample, 1 every 2nd, 2 every 4th, 3 every 8th); registered when `start` is accepted.
- `s_data`  in  DATA_W: ADC sample.
- `s_valid`  in  1: sample present.
- `s_ready`  out  1: controller accepts a sample.
- `cnt_load`  out  1: load strobe to the frame counter.
- `cnt_inc`  out  1: increment strobe to the frame counter.
- `cnt_din`  out  9: counter load value (always 0).
- `count`  in  9: frame counter value.
- `md512`  in  1: high when `count` is 511.
- `mem_we`  out  1: sample RAM write enable.
- `mem_addr`  out  9: RAM address, equal to `count` bit-reversed (`mem_addr[i] = count[8-i]`).
- `mem_wdata`  out  DATA_W: equal to `s_data`.
- `busy`  out  1: high in LOAD, CAPTURE and DONE.
- `frame_done`  out  1: one-cycle pulse when a frame completes.
- `overrun`  out  1: sticky flag for a sample presented while it cannot be accepted.

## Operation
- The state machine has four states: IDLE, LOAD, CAPTURE, DONE.
- **IDLE**
  - `s_ready` = 0.
  - `start` with no `abort` moves to LOAD, latches `dec_sel` and clears `overrun`.
  - `start` together with `abort` stays in IDLE.
- **LOAD** (one cycle)
  - Drives `cnt_load` = 1 and `cnt_din` = 0.
  - Clears the 3-bit decimation prescaler.
  - Moves to CAPTURE.
- **CAPTURE**
  - `s_ready` = 1.
  - A sample is accepted when `s_valid & s_ready`.
  - An accepted sample is kept when the prescaler's low `dec_sel` bits are 0.
  - The prescaler increments on every accepted sample and wraps modulo 8.
  - A kept sample drives `mem_we` = 1 in the same cycle.
  - A kept sample also drives `cnt_inc` = 1, unless `md512` = 1. On the 512th kept sample the write still happens, `cnt_inc` stays 0, and the state moves to DONE.
- **DONE** (one cycle)
  - `frame_done` = 1.
  - Moves to IDLE.
- **abort** in LOAD or CAPTURE:
  - Takes priority over a write: no `mem_we` and no `cnt_inc` that cycle.
  - State is IDLE on the next cycle, with no `frame_done`.
  - RAM contents are partial.
  - `abort` in DONE is ignored.
- `start` is ignored while `busy` = 1.
- `overrun` is set when `s_valid` = 1 in LOAD or DONE. It stays set until the next accepted `start`.

## Timing
- On reset, every output is 0, the state is IDLE and the prescaler is 0.
- Reset takes effect immediately (asynchronously), including mid-frame.
- `s_ready`, `cnt_load`, `cnt_inc`, `mem_we`, `busy` and `frame_done` are decoded from registered state plus same-cycle inputs.
- `mem_addr` is combinational from `count`.
- The counter updates on the edge after `cnt_inc`, so successive kept samples may arrive on consecutive cycles (throughput of 1 per clock).
- Latency from `start` (cycle t): LOAD at t+1, first possible write at t+2.
- `frame_done` asserts the cycle after the final write. `busy` falls the cycle after that.

## Structure
- Shared package `spec_pkg`:
  - State enum (IDLE, LOAD, CAPTURE, DONE).
  - `FRAME_LEN` = 512, `FRAME_AW` = 9, `DATA_W` default.
  - `dec_sel` encoding constants.
- Sub-module `decim_prescaler`: 3-bit counter with clear and enable; outputs `keep` given the registered `dec_sel`.
- The bit reversal is a wire permutation in the top module.

## Test plan
- **Full-rate frame.** Reset, `start` with `dec_sel`=0, then 512 samples with `s_data` equal to the sample index.
  - Exactly 512 `mem_we`.
  - Sample 1 goes to `mem_addr` 256, sample 2 to 128, sample 511 to 511.
  - `frame_done` pulses once, one cycle after the last write; `cnt_inc` is never asserted while `md512` = 1.
- **Decimation by 4.** `dec_sel`=2 with 2048 samples.
  - 512 writes.
  - Written data is 0, 4, 8, … at addresses 0, 256, 128, ….
- **Abort.** `abort` on the cycle of kept sample 100.
  - No write that cycle and none afterwards; no `frame_done`; `busy` = 0 on the next cycle.
  - A following `start` writes its first sample at address 0.
- **Overrun.** `s_valid` high during LOAD.
  - `overrun` = 1 and holds through the whole frame.
  - The next accepted `start` clears it.
- **Async reset.** Drive `Resetn` low mid-frame at `count` = 300.
  - All outputs 0 before the next clock edge.
  - After release, the state is IDLE and `s_ready` = 0.
- **Simultaneous controls.**
  - `start` with `abort` in IDLE: the block stays in IDLE.
  - `start` during CAPTURE is ignored and the frame completes normally.
